// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: owns HI/LO and runs multi-cycle MULT/MULTU/DIV/DIVU.
// Define MDU_MADD_EN to add MADD/MADDU (ops 7/8) accumulating into {HI,LO}.
`timescale 1ns/1ps
module e_mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        int_req,
  input  logic [3:0]  op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  output logic        start,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MULT = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      a_q, a_d, b_q, b_d;
  logic             sgn_q, sgn_d;
  logic             accept, is_mul, is_div, is_signed;
  logic [63:0]      mul_res, div_res;
`ifdef MDU_MADD_EN
  logic             acc_q, acc_d;
  logic [63:0]      acc_base_q, acc_base_d;
`endif

  // Low 64 bits of the product of operands extended to 64 bits cover both signednesses.
  function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic signed [63:0] ea, eb, prod;
    ea   = sgn ? $signed({{32{a[31]}}, a}) : $signed({32'b0, a});
    eb   = sgn ? $signed({{32{b[31]}}, b}) : $signed({32'b0, b});
    prod = ea * eb;
    return $unsigned(prod);
  endfunction

  // Magnitude divide then re-sign; returns {remainder, quotient}.
  function automatic logic [63:0] div32(input logic [31:0] a, input logic [31:0] b,
                                        input logic sgn);
    logic [31:0] ma, mb, q, r;
    logic        neg_q, neg_r;
    neg_q = sgn && (a[31] ^ b[31]);
    neg_r = sgn && a[31];
    ma    = (sgn && a[31]) ? -a : a;
    mb    = (sgn && b[31]) ? -b : b;
    q     = (mb == 32'd0) ? 32'd0 : ma / mb;
    r     = (mb == 32'd0) ? 32'd0 : ma % mb;
    return {(neg_r ? -r : r), (neg_q ? -q : q)};
  endfunction

  always_comb begin
    is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    is_signed = (op == OP_MULT) || (op == OP_DIV);
`ifdef MDU_MADD_EN
    is_mul    = is_mul || (op == OP_MADD) || (op == OP_MADDU);
    is_signed = is_signed || (op == OP_MADD);
`endif
    is_div    = (op == OP_DIV) || (op == OP_DIVU);
    accept    = !busy_q && !int_req;
    start     = accept && (is_mul || is_div);
  end

  assign mul_res = mul64(a_q, b_q, sgn_q);
  assign div_res = div32(a_q, b_q, sgn_q);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    a_d     = a_q;
    b_d     = b_q;
    sgn_d   = sgn_q;
`ifdef MDU_MADD_EN
    acc_d      = acc_q;
    acc_base_d = acc_base_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d     = rs_data;
          b_d     = rt_data;
          sgn_d   = is_signed;
          busy_d  = 1'b1;
          state_d = is_mul ? S_MULT : S_DIV;
          cnt_d   = is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
`ifdef MDU_MADD_EN
          acc_d      = (op == OP_MADD) || (op == OP_MADDU);
          acc_base_d = {hi_q, lo_q};
`endif
        end else if (accept && op == OP_MTHI) begin
          hi_d = rs_data;
        end else if (accept && op == OP_MTLO) begin
          lo_d = rs_data;
        end
      end
      S_MULT, S_DIV: begin
        cnt_d = cnt_q - CNT_W'(1);
        // Result lands on the same edge that drops busy.
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          if (state_q == S_MULT) begin
`ifdef MDU_MADD_EN
            {hi_d, lo_d} = acc_q ? (mul_res + acc_base_q) : mul_res;
`else
            {hi_d, lo_d} = mul_res;
`endif
          end else if (b_q != 32'd0) begin
            {hi_d, lo_d} = div_res;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
`ifdef MDU_MADD_EN
      acc_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
`ifdef MDU_MADD_EN
      acc_q   <= acc_d;
`endif
    end
  end

  // Operand latches are only meaningful while busy, so they carry no reset.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    sgn_q <= sgn_d;
`ifdef MDU_MADD_EN
    acc_base_q <= acc_base_d;
`endif
  end

  assign busy = busy_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed scenarios plus randomized ops against a cycle-level reference.
`timescale 1ns/1ps
module tb_e_mdu;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        int_req;
  logic [3:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        start, busy;
  logic [31:0] hi, lo;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .int_req(int_req), .op(op),
    .rs_data(rs_data), .rt_data(rt_data),
    .start(start), .busy(busy), .hi(hi), .lo(lo)
  );

  // Reference: decode an op into (result, write-enable, busy length); length 0 = not a start op.
  function automatic void ref_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] h, input logic [31:0] l,
                                 output logic [63:0] res, output logic wr, output int cyc);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    res = 64'd0;
    wr = 1'b1;
    cyc = 0;
    case (o)
      4'd1: begin res = 64'(sa * sb); cyc = MC; end
      4'd2: begin res = ua * ub; cyc = MC; end
      4'd3: begin
        cyc = DC;
        if (b == 32'd0) wr = 1'b0;
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      4'd4: begin
        cyc = DC;
        if (b == 32'd0) wr = 1'b0;
        else res = {32'(ua % ub), 32'(ua / ub)};
      end
`ifdef MDU_MADD_EN
      4'd7: begin res = {h, l} + 64'(sa * sb); cyc = MC; end
      4'd8: begin res = {h, l} + ua * ub; cyc = MC; end
`endif
      default: cyc = 0;
    endcase
  endfunction

  logic [31:0] m_hi, m_lo;
  int          m_rem;
  logic        m_wr;
  logic [63:0] m_res;
  logic [63:0] e_res;
  logic        e_wr;
  int          e_cyc;
  logic        m_start;

  always_comb begin
    ref_op(op, rs_data, rt_data, m_hi, m_lo, e_res, e_wr, e_cyc);
    m_start = (e_cyc > 0) && (m_rem == 0) && !int_req;
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_hi <= '0; m_lo <= '0; m_rem <= 0; m_wr <= 1'b0; m_res <= '0;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1 && m_wr) begin
        m_hi <= m_res[63:32];
        m_lo <= m_res[31:0];
      end
    end else if (!int_req) begin
      if (e_cyc > 0) begin
        m_rem <= e_cyc; m_res <= e_res; m_wr <= e_wr;
      end else if (op == 4'd5) m_hi <= rs_data;
      else if (op == 4'd6) m_lo <= rs_data;
    end
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drv(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b, input logic ir);
    op = o; rs_data = a; rt_data = b; int_req = ir;
  endtask

  task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic ir, output logic st);
    drv(o, a, b, ir);
    #1 st = start;
    tick;
    drv(4'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic run(input int n, output int nb);
    nb = 0;
    for (int i = 0; i < n; i++) begin
      if (busy === 1'b1) nb++;
      tick;
    end
  endtask

  task automatic test_reset;
    drv(4'd0, 32'd0, 32'd0, 1'b0);
    #1;
    vectors++;
    if ({start, busy, hi, lo} !== 66'd0) begin
      miscompares++;
      $display("FAIL reset_state: got start=%b busy=%b hi=%h lo=%h, want all zero", start, busy, hi, lo);
    end
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_mult;
    logic st; int nb;
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo;
    issue(4'd1, 32'hFFFFFFFE, 32'd3, 1'b0, st);
    vectors++;
    if (st !== 1'b1) begin miscompares++; $display("FAIL mult_start: got %b want 1", st); end
    run(MC - 1, nb);
    vectors++;
    if (nb != MC - 1 || busy !== 1'b1 || {hi, lo} !== {h0, l0}) begin
      miscompares++;
      $display("FAIL mult_inflight: busy_cycles=%0d busy=%b hi=%h lo=%h want %0d,1,%h,%h", nb, busy, hi, lo, MC - 1, h0, l0);
    end
    tick;
    vectors++;
    if ({busy, hi, lo} !== {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFA}) begin
      miscompares++;
      $display("FAIL mult_result: got busy=%b hi=%h lo=%h want 0 ffffffff fffffffa", busy, hi, lo);
    end
    issue(4'd2, 32'hFFFFFFFE, 32'd3, 1'b0, st);
    run(MC, nb);
    vectors++;
    if (st !== 1'b1 || nb != MC || {busy, hi, lo} !== {1'b0, 32'h00000002, 32'hFFFFFFFA}) begin
      miscompares++;
      $display("FAIL multu_result: got start=%b busy_cycles=%0d hi=%h lo=%h want 1 %0d 00000002 fffffffa", st, nb, hi, lo, MC);
    end
  endtask

  task automatic test_div;
    logic st; int nb;
    issue(4'd3, 32'hFFFFFFF9, 32'd2, 1'b0, st);
    run(DC - 1, nb);
    vectors++;
    if (st !== 1'b1 || nb != DC - 1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL div_inflight: start=%b busy_cycles=%0d busy=%b want 1 %0d 1", st, nb, busy, DC - 1);
    end
    tick;
    vectors++;
    if ({busy, hi, lo} !== {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD}) begin
      miscompares++;
      $display("FAIL div_result: got busy=%b hi=%h lo=%h want 0 ffffffff fffffffd", busy, hi, lo);
    end
    issue(4'd4, 32'd7, 32'd0, 1'b0, st);
    run(DC, nb);
    vectors++;
    if (nb != DC || {busy, hi, lo} !== {1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD}) begin
      miscompares++;
      $display("FAIL divu_by_zero: got busy_cycles=%0d hi=%h lo=%h want %0d ffffffff fffffffd", nb, hi, lo, DC);
    end
    issue(4'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, st);
    run(DC, nb);
    vectors++;
    if ({busy, hi, lo} !== {1'b0, 32'h00000000, 32'h80000000}) begin
      miscompares++;
      $display("FAIL div_overflow: got hi=%h lo=%h want 00000000 80000000", hi, lo);
    end
  endtask

  task automatic test_mthi;
    logic st; int nb;
    issue(4'd5, 32'h12345678, 32'd0, 1'b0, st);
    vectors++;
    if (st !== 1'b0 || hi !== 32'h12345678 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL mthi_idle: got start=%b hi=%h busy=%b want 0 12345678 0", st, hi, busy);
    end
    issue(4'd6, 32'h0BADF00D, 32'd0, 1'b0, st);
    vectors++;
    if (lo !== 32'h0BADF00D) begin miscompares++; $display("FAIL mtlo_idle: got %h want 0badf00d", lo); end
    issue(4'd1, 32'd7, 32'd6, 1'b0, st);
    drv(4'd5, 32'hDEADBEEF, 32'd0, 1'b0);
    run(MC - 1, nb);
    vectors++;
    if ({busy, hi, lo} !== {1'b1, 32'h12345678, 32'h0BADF00D}) begin
      miscompares++;
      $display("FAIL mthi_while_busy: got busy=%b hi=%h lo=%h want 1 12345678 0badf00d", busy, hi, lo);
    end
    tick;
    vectors++;
    if ({busy, hi, lo} !== {1'b0, 32'd0, 32'd42}) begin
      miscompares++;
      $display("FAIL mult_after_mthi: got busy=%b hi=%h lo=%h want 0 00000000 0000002a", busy, hi, lo);
    end
    drv(4'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic test_intreq;
    logic st; int nb;
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo;
    issue(4'd1, 32'd5, 32'd5, 1'b1, st);
    vectors++;
    if (st !== 1'b0 || {busy, hi, lo} !== {1'b0, h0, l0}) begin
      miscompares++;
      $display("FAIL intreq_cancel_mult: got start=%b busy=%b hi=%h lo=%h want 0 0 %h %h", st, busy, hi, lo, h0, l0);
    end
    issue(4'd5, 32'hAAAA5555, 32'd0, 1'b1, st);
    vectors++;
    if (hi !== h0) begin miscompares++; $display("FAIL intreq_cancel_mthi: got hi=%h want %h", hi, h0); end
    issue(4'd3, 32'd100, 32'd7, 1'b0, st);
    run(2, nb);
    drv(4'd1, 32'd9, 32'd9, 1'b1);
    tick;
    drv(4'd0, 32'd0, 32'd0, 1'b0);
    run(DC - 4, nb);
    vectors++;
    if (busy !== 1'b1) begin miscompares++; $display("FAIL intreq_div_inflight: got busy=%b want 1", busy); end
    tick;
    vectors++;
    if ({busy, hi, lo} !== {1'b0, 32'd2, 32'd14}) begin
      miscompares++;
      $display("FAIL intreq_div_commit: got busy=%b hi=%h lo=%h want 0 00000002 0000000e", busy, hi, lo);
    end
  endtask

  task automatic test_reset_mid;
    logic st; int nb;
    issue(4'd5, 32'd1, 32'd0, 1'b0, st);
    issue(4'd6, 32'd2, 32'd0, 1'b0, st);
    issue(4'd1, 32'd3, 32'd3, 1'b0, st);
    tick;
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({busy, hi, lo} !== 65'd0) begin
      miscompares++;
      $display("FAIL reset_async: got busy=%b hi=%h lo=%h want all zero", busy, hi, lo);
    end
    @(negedge clk) reset = 1'b1;
    run(MC + 3, nb);
    vectors++;
    if (nb != 0 || {busy, hi, lo} !== 65'd0) begin
      miscompares++;
      $display("FAIL reset_no_commit: got busy_cycles=%0d hi=%h lo=%h want 0 0 0", nb, hi, lo);
    end
  endtask

  task automatic test_madd;
    logic st; int nb;
`ifdef MDU_MADD_EN
    issue(4'd5, 32'd0, 32'd0, 1'b0, st);
    issue(4'd6, 32'hFFFFFFFF, 32'd0, 1'b0, st);
    issue(4'd8, 32'd1, 32'd1, 1'b0, st);
    run(MC, nb);
    vectors++;
    if (st !== 1'b1 || nb != MC || {busy, hi, lo} !== {1'b0, 32'd1, 32'd0}) begin
      miscompares++;
      $display("FAIL maddu_carry: got start=%b busy_cycles=%0d hi=%h lo=%h want 1 %0d 00000001 00000000", st, nb, hi, lo, MC);
    end
    issue(4'd7, 32'hFFFFFFFF, 32'd1, 1'b0, st);
    run(MC, nb);
    vectors++;
    if ({hi, lo} !== {32'd0, 32'hFFFFFFFF}) begin
      miscompares++;
      $display("FAIL madd_signed: got hi=%h lo=%h want 00000000 ffffffff", hi, lo);
    end
`else
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo;
    issue(4'd7, 32'd3, 32'd4, 1'b0, st);
    vectors++;
    if (st !== 1'b0 || {busy, hi, lo} !== {1'b0, h0, l0}) begin
      miscompares++;
      $display("FAIL madd_disabled: got start=%b busy=%b hi=%h lo=%h want 0 0 %h %h", st, busy, hi, lo, h0, l0);
    end
    issue(4'd8, 32'd3, 32'd4, 1'b0, st);
    vectors++;
    if (st !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL maddu_disabled: got start=%b busy=%b want 0 0", st, busy);
    end
`endif
  endtask

  task automatic test_back_to_back;
    logic st; int nb;
    issue(4'd1, 32'd2, 32'd3, 1'b0, st);
    run(MC, nb);
    issue(4'd4, 32'd42, 32'd5, 1'b0, st);
    vectors++;
    if (st !== 1'b1 || busy !== 1'b1 || lo !== 32'd6) begin
      miscompares++;
      $display("FAIL b2b_accept: got start=%b busy=%b lo=%h want 1 1 00000006", st, busy, lo);
    end
    run(DC, nb);
    vectors++;
    if ({busy, hi, lo} !== {1'b0, 32'd2, 32'd8}) begin
      miscompares++;
      $display("FAIL b2b_result: got busy=%b hi=%h lo=%h want 0 00000002 00000008", busy, hi, lo);
    end
  endtask

  task automatic test_random;
    logic [3:0] o;
    logic [31:0] a, b;
    logic ir;
    for (int i = 0; i < 600; i++) begin
      o  = 4'($urandom_range(0, 9));
      if ($urandom_range(0, 15) == 0) o = 4'($urandom_range(9, 15));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 7) == 0) b = 32'd0;
      if ($urandom_range(0, 15) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      if ($urandom_range(0, 7) == 0) b = 32'($urandom_range(1, 20));
      ir = ($urandom_range(0, 9) == 0);
      drv(o, a, b, ir);
      #1;
      vectors++;
      if (start !== m_start) begin
        miscompares++;
        $display("FAIL rand_start[%0d]: op=%0d got %b want %b", i, o, start, m_start);
      end
      tick;
      vectors++;
      if ({busy, hi, lo} !== {(m_rem > 0), m_hi, m_lo}) begin
        miscompares++;
        $display("FAIL rand_state[%0d]: got busy=%b hi=%h lo=%h want %b %h %h", i, busy, hi, lo, (m_rem > 0), m_hi, m_lo);
      end
    end
    drv(4'd0, 32'd0, 32'd0, 1'b0);
    for (int i = 0; i < DC + 1; i++) tick;
  endtask

  initial begin
    reset = 1'b0;
    drv(4'd0, 32'd0, 32'd0, 1'b0);
    repeat (2) @(negedge clk);
    test_reset;
    test_mult;
    test_div;
    test_mthi;
    test_intreq;
    test_back_to_back;
    test_reset_mid;
    test_madd;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
